// File: rtl/arb_pkg.sv
// Shared types and helpers for the arbitration request agent.
package arb_pkg;

    // Agent sequencing: wait for work, present requests, hold a granted index.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Width of a binary index able to name any of n sources (at least 1 bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Encodes a grant vector to a binary index and reports whether it is one-hot.
module onehot_to_bin
    import arb_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]          vec,
    output logic [idx_w(N)-1:0]   idx,
    output logic                  onehot
);

    localparam int W = idx_w(N);

    // OR-reduce the positions of set bits; exact only when vec is one-hot.
    always_comb begin
        // NOTE: every output gets a default before any conditional write, so no latch is inferred.
        idx    = '0;
        onehot = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = idx | W'(i);
            end
        end
        onehot = (vec != '0) && ((vec & (vec - N'(1))) == '0);
    end

endmodule

// File: rtl/arb_req_agent.sv
// Per-source pending-request counters feeding an external LSB-priority
// arbiter; each legal grant is emitted downstream as a binary index.
module arb_req_agent
    import arb_pkg::*;
#(
    parameter int N     = 8,
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N-1:0]          push,
    output logic [N-1:0]          full,
    output logic [N-1:0]          req,
    input  logic [N-1:0]          gnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [idx_w(N)-1:0]   out_idx,
    output logic                  err_gnt,
    output logic [N-1:0]          drop
);

    localparam int               W       = idx_w(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt      [N];
    logic [CNT_W-1:0] cnt_next [N];
    logic [N-1:0]     drop_next;
    logic [N-1:0]     pending;
    logic [N-1:0]     dec;
    logic [W-1:0]     gnt_idx;
    logic             gnt_onehot;
    logic             gnt_legal;
    logic             gnt_take;
    logic             gnt_bad;
    logic             any_next;

    onehot_to_bin #(.N(N)) u_enc (
        .vec    (gnt),
        .idx    (gnt_idx),
        .onehot (gnt_onehot)
    );

    // Per-source status straight from the registered counters.
    always_comb begin
        pending = '0;
        full    = '0;
        for (int i = 0; i < N; i++) begin
            pending[i] = (cnt[i] != '0);
            full[i]    = (cnt[i] == CNT_MAX);
        end
    end

    // Requests are only exposed while the agent waits for a grant.
    assign req       = (state == REQ) ? pending : '0;
    assign gnt_legal = gnt_onehot && ((gnt & ~req) == '0);
    assign gnt_take  = (state == REQ) && gnt_legal;
    assign gnt_bad   = (state == REQ) && (gnt != '0) && !gnt_legal;
    assign dec       = gnt_take ? gnt : '0;

    // Next counter values: a push and a grant on one source cancel out;
    // a push to a saturated counter is discarded and remembered in drop.
    always_comb begin
        drop_next = drop;
        any_next  = 1'b0;
        for (int i = 0; i < N; i++) begin
            cnt_next[i] = cnt[i];
            if (push[i] && !dec[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    drop_next[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end else if (dec[i] && !push[i] && (cnt[i] != '0)) begin
                cnt_next[i] = cnt[i] - CNT_W'(1);
            end
            any_next = any_next | (cnt_next[i] != '0);
        end
    end

    // Counter and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignment so every register samples pre-edge values.
        if (!rst_n) begin
            // NOTE: the counter array is a handful of flops, not a RAM, so it is reset like any register.
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
            drop <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                cnt[i] <= cnt_next[i];
            end
            drop <= drop_next;
        end
    end

    // Sequencing FSM with registered out_valid, out_idx and err_gnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_idx   <= '0;
            err_gnt   <= 1'b0;
        end else begin
            err_gnt <= gnt_bad;
            case (state)
                IDLE: begin
                    if (pending != '0) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    if (gnt_take) begin
                        out_idx   <= gnt_idx;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= any_next ? REQ : IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/arb_req_agent.md
ARB_REQ_AGENT -- requirements
Module: arb_req_agent

Interface
REQ-001 Parameter N, default 8, SHALL be the number of request sources (N >= 2).
REQ-002 Parameter CNT_W, default 4, SHALL be the width of each per-source pending counter.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-005 Port push, input, N, SHALL be the per-source one-cycle request pulses; bit i adds one pending request to source i.
REQ-006 Port full, output, N, SHALL flag source i's counter at 2^CNT_W-1.
REQ-007 Port req, output, N, SHALL be the request vector presented to an external LSB-priority arbiter.
REQ-008 Port gnt, input, N, SHALL be the grant vector returned combinationally by that arbiter.
REQ-009 Port out_valid, output, 1, SHALL qualify out_idx.
REQ-010 Port out_ready, input, 1, SHALL be the downstream accept.
REQ-011 Port out_idx, output, $clog2(N), SHALL be the binary index of the granted source.
REQ-012 Port err_gnt, output, 1, SHALL pulse for one cycle on an illegal grant.
REQ-013 Port drop, output, N, SHALL be sticky per-source overflow flags.

Function
REQ-014 FSM states SHALL be IDLE, REQ, OUT.
REQ-015 IDLE: go to REQ when any counter is nonzero; req SHALL be 0.
REQ-016 REQ: req[i] SHALL equal (cnt[i] != 0), driven combinationally from the counters.
REQ-017 REQ: the gnt vector SHALL be legal only if it is one-hot and gnt & ~req == 0.
REQ-018 REQ, legal gnt: capture the binary index, decrement that counter, and go to OUT; out_valid SHALL rise on the next cycle (latency 1).
REQ-019 REQ, gnt == 0: remain in REQ, no state change.
REQ-020 REQ, illegal nonzero gnt: err_gnt pulses, counters unchanged, remain in REQ.
REQ-021 OUT: req SHALL be 0; out_valid = 1; out_idx SHALL be held stable until out_ready.
REQ-022 OUT and out_ready: go to REQ if any counter is nonzero after this cycle's updates, else go to IDLE.
REQ-023 A push to a non-full counter SHALL increment it in any state.
REQ-024 A push to a full counter SHALL be discarded and set drop[i]; drop clears only on reset.
REQ-025 A push and a decrement of the same counter in the same cycle SHALL leave the counter unchanged, including when the counter is full (no drop).
REQ-026 Counters SHALL never wrap: there SHALL be no decrement below 0 and no increment above 2^CNT_W-1.
REQ-027 full[i] SHALL be registered-state derived (cnt[i] == max), with no combinational path from push.

Reset
REQ-028 On rst_n low, the block SHALL immediately enter IDLE, clear all counters, and clear drop; out_valid, req, err_gnt and out_idx SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL abandon any captured grant without emitting it.
REQ-030 Reset deassertion SHALL take effect on the first clk edge after rst_n rises.

Structure
REQ-031 The FSM state enum and the index-width function SHALL reside in the shared package arb_pkg.
REQ-032 One sub-module, onehot_to_bin (parameter N), SHALL perform the grant-to-index encoding and report the one-hot check.

Verification
REQ-033 Check push=8'b0000_0101 with arbiter connected: the bench SHALL see out_idx=0 first, then out_idx=2, after which both counters are 0 and the FSM is in IDLE.
REQ-034 Check gnt=8'b0000_0011 forced in REQ: err_gnt SHALL pulse once, counters SHALL be unchanged, and there SHALL be no out_valid.
REQ-035 Check 16 pushes to source 3 with CNT_W=4: full[3]=1 after 15, and drop[3]=1 with cnt=15 after the 16th.
REQ-036 Check out_ready held low for 5 cycles in OUT: out_valid and out_idx SHALL remain stable, req SHALL remain 0, and pushes SHALL still count.
REQ-037 Check rst_n asserted while in OUT: out_valid SHALL fall asynchronously, and the FSM SHALL be in IDLE with counters at 0 after release.
REQ-038 Check a simultaneous push and grant on source 1 with cnt=1: cnt[1] SHALL remain 1, and the FSM SHALL re-enter REQ after out_ready.
